// File: rtl/ip_codma_pkg.sv
// ip_codma_pkg: shared types, size codes and beat-count helper for the codma read/write machines.
package ip_codma_pkg;

   typedef enum logic [1:0] {
      WR_IDLE    = 2'd0,
      WR_ASK     = 2'd1,
      WR_GRANTED = 2'd2,
      WR_UNUSED  = 2'd3
   } write_state_t;

   typedef enum logic [2:0] {
      DMA_IDLE  = 3'd0,
      DMA_READ  = 3'd1,
      DMA_WRITE = 3'd2,
      DMA_DONE  = 3'd3,
      DMA_ERROR = 3'd4
   } dma_state_t;

   localparam logic [3:0] SIZE_2W = 4'd3;
   localparam logic [3:0] SIZE_6W = 4'd8;
   localparam logic [3:0] SIZE_8W = 4'd9;

   // Zero beats marks an illegal size code.
   function automatic logic [2:0] size_beats(input logic [3:0] size);
      return (size == SIZE_8W) ? 3'd4 :
             (size == SIZE_6W) ? 3'd3 :
             (size == SIZE_2W) ? 3'd1 : 3'd0;
   endfunction

endpackage

// File: rtl/mem_interface.sv
// mem_interface: codma memory bus with request/grant arbitration and a valid/ready write channel.
interface mem_interface;
   logic        req;
   logic        write;
   logic [31:0] addr;
   logic [3:0]  size;
   logic [63:0] write_data;
   logic        write_valid;
   logic        grant;
   logic        write_ready;
   logic        error;

   modport master (
      output req, write, addr, size, write_data, write_valid,
      input  grant, write_ready, error
   );

   modport slave (
      input  req, write, addr, size, write_data, write_valid,
      output grant, write_ready, error
   );
endinterface

// File: rtl/ip_codma_write_machine.sv
// ip_codma_write_machine: bursts the 8x32 data register to memory as 64-bit beats.
// Moore outputs; stop beats fault, fault beats the normal transitions.
module ip_codma_write_machine
   import ip_codma_pkg::*;
(
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              need_write_i,
   input  logic              stop_i,
   input  logic [31:0]       addr_i,
   input  logic [3:0]        size_i,
   input  logic [7:0][31:0]  data_reg_i,
   output logic              wr_done_o,
   output logic              wr_state_error,
   mem_interface.master      bus_if,
   output write_state_t      wr_state_r,
   output write_state_t      wr_state_next_s,
   input  dma_state_t        dma_state_r
);

   logic [31:0]      addr_r;
   logic [3:0]       size_r;
   logic [7:0][31:0] data_r;
   logic [2:0]       idx;
   logic [2:0]       last_idx;
   logic             fault, accept, legal, fire, last;

   assign fault    = bus_if.error | (dma_state_r == DMA_ERROR);
   assign accept   = (wr_state_r == WR_IDLE) & need_write_i & ~stop_i & ~fault;
   assign legal    = size_beats(size_i) != 3'd0;
   assign fire     = (wr_state_r == WR_GRANTED) & bus_if.write_ready;
   assign last_idx = 3'({size_beats(size_r), 1'b0} - 4'd2);
   assign last     = fire & (idx == last_idx);

   always_comb begin
      case (wr_state_r)
         WR_IDLE:    wr_state_next_s = accept ? (legal ? WR_ASK : WR_UNUSED) : WR_IDLE;
         WR_ASK:     wr_state_next_s = bus_if.grant ? WR_GRANTED : WR_ASK;
         WR_GRANTED: wr_state_next_s = last ? WR_IDLE : WR_GRANTED;
         default:    wr_state_next_s = WR_IDLE;
      endcase
      if (stop_i || fault) wr_state_next_s = WR_IDLE;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_state_r     <= WR_IDLE;
         wr_done_o      <= 1'b0;
         wr_state_error <= 1'b0;
         addr_r         <= '0;
         size_r         <= '0;
         data_r         <= '0;
         idx            <= '0;
      end else begin
         wr_state_r     <= wr_state_next_s;
         wr_done_o      <= last & ~stop_i & ~fault;
         wr_state_error <= stop_i ? wr_state_error : fault ? 1'b1 : accept ? ~legal : wr_state_error;
         idx            <= (accept || wr_state_next_s == WR_IDLE) ? 3'd0 : fire ? idx + 3'd2 : idx;
         if (accept) begin
            addr_r <= addr_i;
            size_r <= size_i;
            data_r <= data_reg_i;
         end
      end
   end

   // idx is always even, so the upper word of the pair is idx with bit 0 set.
   assign bus_if.req         = (wr_state_r == WR_ASK) | (wr_state_r == WR_GRANTED);
   assign bus_if.write       = bus_if.req;
   assign bus_if.addr        = addr_r;
   assign bus_if.size        = size_r;
   assign bus_if.write_valid = wr_state_r == WR_GRANTED;
   assign bus_if.write_data  = {data_r[{idx[2:1], 1'b1}], data_r[idx]};

endmodule

// File: tb/tb_ip_codma_write_machine.sv
// tb_ip_codma_write_machine: table-driven bursts plus directed stop/error/illegal/reset sequences.
module tb_ip_codma_write_machine;
   import ip_codma_pkg::*;

   typedef struct {
      logic [3:0]  sz;
      int          beats;
      logic [31:0] addr;
      logic [31:0] base;
      int          gdelay;
      bit          toggle;
   } vec_t;

   logic             clk = 0;
   logic             rst_n = 0;
   logic             need = 0;
   logic             stop = 0;
   logic [31:0]      addr = '0;
   logic [3:0]       size = '0;
   logic [7:0][31:0] data = '0;
   logic             done, err;
   write_state_t     st, nst;
   dma_state_t       dma_st = DMA_IDLE;
   int               checks = 0;
   int               errors = 0;
   vec_t             tbl [5];

   mem_interface bus ();

   ip_codma_write_machine dut (
      .clk_i           (clk),
      .reset_n_i       (rst_n),
      .need_write_i    (need),
      .stop_i          (stop),
      .addr_i          (addr),
      .size_i          (size),
      .data_reg_i      (data),
      .wr_done_o       (done),
      .wr_state_error  (err),
      .bus_if          (bus),
      .wr_state_r      (st),
      .wr_state_next_s (nst),
      .dma_state_r     (dma_st)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic fill(input logic [31:0] base);
      for (int i = 0; i < 8; i++) data[i] = base + 32'(i);
   endtask

   task automatic do_burst(input vec_t v);
      int k;
      int cyc;
      logic [63:0] e;
      @(negedge clk);
      need = 1; addr = v.addr; size = v.sz; fill(v.base);
      #1 chk("next_ask", 64'(nst), 64'(WR_ASK));
      @(negedge clk);
      need = 0; addr = '0; size = '0; data = '0;
      chk("ask_state", 64'(st), 64'(WR_ASK));
      chk("ask_req", 64'(bus.req), 1);
      chk("ask_write", 64'(bus.write), 1);
      chk("ask_addr", 64'(bus.addr), 64'(v.addr));
      chk("ask_size", 64'(bus.size), 64'(v.sz));
      chk("ask_valid", 64'(bus.write_valid), 0);
      chk("accept_err_clr", 64'(err), 0);
      for (int g = 0; g < v.gdelay; g++) begin
         @(negedge clk);
         chk("wait_state", 64'(st), 64'(WR_ASK));
         chk("wait_req", 64'(bus.req), 1);
      end
      bus.grant = 1;
      @(negedge clk);
      bus.grant = 0;
      chk("granted", 64'(st), 64'(WR_GRANTED));
      k = 0; cyc = 0;
      while (k < v.beats && cyc < 40) begin
         e = {v.base + 32'(2 * k + 1), v.base + 32'(2 * k)};
         chk("beat_valid", 64'(bus.write_valid), 1);
         chk("beat_req", 64'(bus.req), 1);
         chk("beat_data", bus.write_data, e);
         chk("beat_nodone", 64'(done), 0);
         bus.write_ready = v.toggle ? (cyc % 2 == 0) : 1'b1;
         @(negedge clk);
         if (bus.write_ready) k++;
         cyc++;
      end
      if (cyc >= 40) chk("beat_timeout", 64'(cyc), 64'(v.beats));
      bus.write_ready = 0;
      chk("end_state", 64'(st), 64'(WR_IDLE));
      chk("end_done", 64'(done), 1);
      chk("end_req", 64'(bus.req), 0);
      chk("end_valid", 64'(bus.write_valid), 0);
      @(negedge clk);
      chk("done_pulse", 64'(done), 0);
   endtask

   task automatic start(input logic [3:0] sz, input logic [31:0] base);
      @(negedge clk);
      need = 1; size = sz; addr = 32'h8000; fill(base);
      @(negedge clk);
      need = 0; bus.grant = 1;
      @(negedge clk);
      bus.grant = 0;
      chk("start_granted", 64'(st), 64'(WR_GRANTED));
   endtask

   initial begin
      tbl[0] = '{4'd3, 1, 32'h1000, 32'hA0, 2, 1'b0};
      tbl[1] = '{4'd9, 4, 32'h2000, 32'h10, 0, 1'b1};
      tbl[2] = '{4'd8, 3, 32'h3000, 32'h20, 1, 1'b0};
      tbl[3] = '{4'd9, 4, 32'h4000, 32'hC0, 0, 1'b0};
      tbl[4] = '{4'd8, 3, 32'h5000, 32'hE0, 3, 1'b1};
      bus.grant = 0; bus.write_ready = 0; bus.error = 0;
      #12;
      chk("rst_state", 64'(st), 64'(WR_IDLE));
      chk("rst_req", 64'(bus.req), 0);
      chk("rst_write", 64'(bus.write), 0);
      chk("rst_valid", 64'(bus.write_valid), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_err", 64'(err), 0);
      chk("rst_addr", 64'(bus.addr), 0);
      chk("rst_wdata", bus.write_data, 0);
      @(negedge clk);
      rst_n = 1;

      for (int i = 0; i < 5; i++) do_burst(tbl[i]);

      // stop after the first beat of a 3-beat burst
      start(4'd8, 32'h30);
      bus.write_ready = 1;
      @(negedge clk);
      chk("stop_beat2", bus.write_data, 64'h00000033_00000032);
      stop = 1;
      #1 chk("stop_next", 64'(nst), 64'(WR_IDLE));
      @(negedge clk);
      stop = 0; bus.write_ready = 0;
      chk("stop_state", 64'(st), 64'(WR_IDLE));
      chk("stop_done", 64'(done), 0);
      chk("stop_err", 64'(err), 0);
      chk("stop_req", 64'(bus.req), 0);

      // stop coincident with last-beat accept
      start(4'd3, 32'h40);
      bus.write_ready = 1; stop = 1;
      @(negedge clk);
      stop = 0; bus.write_ready = 0;
      chk("stoplast_state", 64'(st), 64'(WR_IDLE));
      chk("stoplast_done", 64'(done), 0);

      // illegal size
      @(negedge clk);
      need = 1; size = 4'd5; fill(32'h90);
      #1 chk("ill_next", 64'(nst), 64'(WR_UNUSED));
      @(negedge clk);
      need = 0;
      chk("ill_state", 64'(st), 64'(WR_UNUSED));
      chk("ill_err", 64'(err), 1);
      chk("ill_req", 64'(bus.req), 0);
      @(negedge clk);
      chk("ill_back", 64'(st), 64'(WR_IDLE));
      chk("ill_err_hold", 64'(err), 1);
      chk("ill_req2", 64'(bus.req), 0);
      do_burst(tbl[0]);

      // bus error then DMA error during the 2nd beat
      for (int m = 0; m < 2; m++) begin
         start(4'd9, 32'h50);
         bus.write_ready = 1;
         @(negedge clk);
         chk("fault_beat2", bus.write_data, 64'h00000053_00000052);
         if (m == 0) bus.error = 1;
         else dma_st = DMA_ERROR;
         @(negedge clk);
         bus.error = 0; dma_st = DMA_IDLE; bus.write_ready = 0;
         chk("fault_state", 64'(st), 64'(WR_IDLE));
         chk("fault_err", 64'(err), 1);
         chk("fault_done", 64'(done), 0);
         chk("fault_req", 64'(bus.req), 0);
         @(negedge clk);
         chk("fault_done2", 64'(done), 0);
      end

      // asynchronous reset mid-burst
      start(4'd9, 32'h60);
      #2 rst_n = 0;
      #1;
      chk("arst_state", 64'(st), 64'(WR_IDLE));
      chk("arst_req", 64'(bus.req), 0);
      chk("arst_valid", 64'(bus.write_valid), 0);
      chk("arst_wdata", bus.write_data, 0);
      chk("arst_addr", 64'(bus.addr), 0);
      chk("arst_err", 64'(err), 0);
      @(negedge clk);
      rst_n = 1;
      do_burst(tbl[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ip_codma_write_machine.md
# ip_codma_write_machine

Write-side bus master of the codma engine and transmit counterpart to the read machine. It takes the 8×32-bit data register filled by the read machine and bursts it to memory over `mem_interface` as 64-bit beats. It arbitrates for the bus, streams the beats with a valid/ready handshake, and reports completion to the DMA controller.

## Interface
- No parameters; burst lengths are fixed by the size encoding in `ip_codma_pkg`.
- `clk_i` input 1: clock.
- `reset_n_i` input 1: reset, asynchronous, active-low.
- `need_write_i` input 1: request to start one write burst; sampled in WR_IDLE only.
- `stop_i` input 1: abort; forces WR_IDLE on the next edge.
- `addr_i` input 32: burst start address, captured on accept.
- `size_i` input 4: size code, captured on accept.
- `data_reg_i` input [7:0][31:0]: payload, captured on accept.
- `wr_done_o` output 1: one-cycle pulse when the last beat is accepted.
- `wr_state_error` output 1: set on illegal size, bus error or DMA error; cleared on the next accept.
- `bus_if` mem_interface.master: drives `req`, `write`, `addr`, `size`, `write_data[63:0]` and `write_valid`; samples `grant`, `write_ready` and `error`.
- `wr_state_r` output write_state_t: registered state.
- `wr_state_next_s` output write_state_t: combinational next state.
- `dma_state_r` input dma_state_t: controller state, used for DMA_ERROR detection.

## Operation
- States:
  - WR_IDLE: no request outstanding.
  - WR_ASK: request raised, waiting for grant.
  - WR_GRANTED: streaming beats.
  - WR_UNUSED: illegal-size trap.
- WR_IDLE → WR_ASK when `need_write_i`=1. On that edge, capture `addr_i`, `size_i` and `data_reg_i`, clear the beat index and clear `wr_state_error`.
- Illegal size: if `size_i` is not 3, 8 or 9 on accept, go WR_IDLE → WR_UNUSED instead of WR_ASK. Set `wr_state_error`. WR_UNUSED → WR_IDLE unconditionally on the next cycle.
- Size map (words / beats):
  - 3 = 2 words / 1 beat.
  - 8 = 6 words / 3 beats.
  - 9 = 8 words / 4 beats.
- WR_ASK: drive `req`=1, `write`=1, and the captured `addr` and `size`. Go to WR_GRANTED on `grant`=1.
- WR_GRANTED:
  - Drive `write_valid`=1 and `write_data` = {data[idx+1], data[idx]}, where idx is the word index, stepped by 2.
  - A beat transfers on a cycle where `write_valid` & `write_ready` are both 1; idx then advances by 2.
  - When the beat with idx = words−2 is accepted, go to WR_IDLE and pulse `wr_done_o`.
- `req` stays high through WR_GRANTED. `write_valid` is 0 in all other states.
- Outputs derive from registered state (Moore style). `write_data` must not change while `write_valid`=1 and `write_ready`=0.
- `stop_i` overrides everything except reset. It sets the next state to WR_IDLE, with no `wr_done_o` and no error.
- `bus_if.error`=1 or `dma_state_r`==DMA_ERROR: the register takes WR_IDLE directly and sets `wr_state_error`; this takes priority over normal transitions.
- The beat index is 3 bits wide and never wraps. Exit happens at the last beat, and the index resets on every WR_IDLE entry.

## Timing
- Reset values:
  - `wr_state_r`=WR_IDLE.
  - `wr_done_o`=0 and `wr_state_error`=0.
  - Captured addr, size and data = 0; beat index = 0.
  - `req`, `write` and `write_valid` = 0.
- Request to bus: `need_write_i` high at edge N gives `req`=1 from cycle N+1.
- Grant to first beat: `grant` sampled at edge M gives `write_valid`=1 from cycle M+1.
- Minimum burst for size 9 with `write_ready` held high: 4 beat cycles; `wr_done_o` is high in the cycle after the 4th accept, coincident with WR_IDLE.
- The earliest new accept is one cycle after returning to WR_IDLE; back-to-back bursts need ≥1 idle cycle.
- Simultaneous `stop_i` and last-beat accept: stop wins, so no `wr_done_o`. The beat has still completed on the bus.
- Reset mid-burst: all outputs drop asynchronously to their reset values.

## Structure
- `ip_codma_pkg` holds:
  - `write_state_t` (2-bit: WR_IDLE, WR_ASK, WR_GRANTED, WR_UNUSED).
  - Size constants SIZE_2W=3, SIZE_6W=8, SIZE_8W=9.
  - A function mapping size to beat count, shared with the read machine.
- Single module. No sub-module: the beat mux is an 8-to-4 word select that stays inline.

## Test plan
- Size 3, addr 0x1000, data words 0..1 = 0xA0/0xA1, grant after 2 cycles, ready always high → one beat `write_data`=0x000000A1_000000A0, `wr_done_o` one cycle, back to WR_IDLE.
- Size 9, words 0x10..0x17, ready toggling 1,0,1,0… → 4 beats in order {0x11,0x10}…{0x17,0x16}, data held stable while stalled, done after the 4th accept.
- Size 8 with `stop_i` asserted after the 1st beat → WR_IDLE next cycle, no `wr_done_o`, `wr_state_error`=0, `req` deasserted.
- Size 5 requested → WR_UNUSED for one cycle, `wr_state_error`=1, `req` never asserted, then WR_IDLE; the next legal request clears the error.
- `bus_if.error` pulse during the 2nd beat of size 9 → WR_IDLE, `wr_state_error`=1, no done. Repeat with `dma_state_r`=DMA_ERROR → same result.
- `reset_n_i` asserted in WR_GRANTED mid-cycle → outputs go to reset values immediately. After release, a fresh size-3 burst completes normally.
